neopix_frame_buffer: RTL and testbench

- Upstream feeder for the NEOPIX serializer: holds a full strip of 24-bit GRB pixel words in a double-buffered memory.
- On command, streams the strip's words to the serializer one at a time over a valid/ready handshake, then enforces the WS2812 latch gap.
- Writers fill the back bank at any time. frame_start swaps banks and displays the new frame, so the display never tears.

---
 rtl/neopix_frame_buffer.sv | 104 ++++++++++
 tb/tb_neopix_frame_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/neopix_frame_buffer.sv
// Double-buffered GRB pixel store feeding the NEOPIX serializer.
// frame_start swaps banks and streams the front bank, then holds the WS2812 latch gap.
module neopix_frame_buffer #(
  parameter int NUM_PIXELS   = 8,
  parameter int ADDR_W       = 3,
  parameter int LATCH_CYCLES = 800
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic [23:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready
);
  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(NUM_PIXELS);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, LATCH} state_t;
  state_t state, state_n;

  logic [23:0]      mem [2][NUM_PIXELS];
  logic             front;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             swap, advance, done_n, hs, wr_ok;

  assign hs    = pix_valid & pix_ready;
  assign wr_ok = wr_en & ({1'b0, wr_addr} < DEPTH);
  // The frame_done cycle still counts as busy, so a new frame_start lands the cycle after.
  assign busy  = (state != IDLE) | frame_done;

  always_comb begin
    state_n = state;
    swap    = 1'b0;
    advance = 1'b0;
    done_n  = 1'b0;
    cnt_n   = cnt;
    case (state)
      IDLE:
        if (frame_start && !frame_done) begin
          swap    = 1'b1;
          state_n = FETCH;
        end
      FETCH: state_n = STREAM;
      STREAM:
        if (hs) begin
          cnt_n = '0;
          if (idx == LAST_IDX) state_n = LATCH;
          else begin
            advance = 1'b1;
            state_n = FETCH;
          end
        end
      LATCH:
        // Only consecutive ready-high cycles count toward the latch gap.
        if (!pix_ready) cnt_n = '0;
        else if (cnt == LAST_CNT) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      front      <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
    end else begin
      frame_done <= done_n;
      cnt        <= cnt_n;
      if (swap) begin
        front <= ~front;
        idx   <= '0;
      end else if (advance) idx <= idx + 1'b1;
      if (state == FETCH) begin
        pix_data  <= mem[front][idx];
        pix_valid <= 1'b1;
      end else if (hs) pix_valid <= 1'b0;
    end
  end

  // Writes use the pre-swap select, so a write beside frame_start hits the bank going on display.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[~front][wr_addr[IDX_W-1:0]] <= wr_data;
  end
endmodule

// File: tb/tb_neopix_frame_buffer.sv
// Scoreboard bench for neopix_frame_buffer: stimulus queues expected pixels and
// frame_done latencies; a negedge monitor checks them along with handshake timing.
module tb_neopix_frame_buffer;
  localparam int NP    = 8;
  localparam int AW    = 4;
  localparam int LC    = 800;
  localparam int GAP   = 480;
  localparam int LIMIT = 10000;

  logic          CLK = 1'b0, RST = 1'b1;
  logic          wr_en = 1'b0, frame_start = 1'b0, pix_ready = 1'b1;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_data = '0;
  logic          busy, frame_done, pix_valid;
  logic [23:0]   pix_data;

  neopix_frame_buffer #(.NUM_PIXELS(NP), .ADDR_W(AW), .LATCH_CYCLES(LC)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  always #5 CLK = ~CLK;

  int          vectors = 0, miscompares = 0;
  logic [23:0] exp_q[$];
  int          done_q[$];
  int          cyc = 0, hs_count = 0, done_count = 0, last_hs_cyc = 0, pos = 0, post = 0;
  logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_rst = 1'b1, after_done = 1'b0;
  logic [23:0] prev_data = '0;
  logic        force_low = 1'b0;
  logic        mon_hs;
  logic [23:0] mon_e;
  int          mon_d;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %06h expected %06h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int t;
    t = 0;
    while (hs_count < target && t < LIMIT) begin tick(); t++; end
    if (hs_count < target) begin
      vectors++; miscompares++;
      $display("FAIL wait_handshake: got %0d handshakes expected %0d", hs_count, target);
    end
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_count < target && t < LIMIT) begin tick(); t++; end
    if (done_count < target) begin
      vectors++; miscompares++;
      $display("FAIL wait_frame_done: got %0d pulses expected %0d", done_count, target);
    end
  endtask

  // Serializer model: after each accepted word, ready stays low GAP cycles.
  initial begin : ready_model
    int  gap_left;
    logic h;
    gap_left = 0;
    forever begin
      @(negedge CLK);
      h = !RST && (pix_valid === 1'b1) && (pix_ready === 1'b1);
      @(posedge CLK); #1;
      if (h) gap_left = GAP;
      if (gap_left > 0) begin gap_left--; pix_ready = 1'b0; end
      else pix_ready = !force_low;
    end
  end

  always @(negedge CLK) begin
    cyc++;
    mon_hs = !RST && (pix_valid === 1'b1) && (pix_ready === 1'b1);
    if (!prev_rst) begin
      if (post == 1) chk("bubble", 24'(pix_valid), 24'd0);
      if (post == 2) chk("refetch", 24'(pix_valid), 24'(pos != 0));
      if (prev_valid && !prev_hs) begin
        chk("hold_valid", 24'(pix_valid), 24'd1);
        chk("hold_data", pix_data, prev_data);
      end
      if (after_done) begin
        chk("done_single_pulse", 24'(frame_done), 24'd0);
        chk("idle_after_done", 24'(busy), 24'd0);
      end
    end
    after_done = 1'b0;
    if (mon_hs) begin
      chk("busy_streaming", 24'(busy), 24'd1);
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_pixel: got %06h expected none at cycle %0d", pix_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pixel", pix_data, mon_e);
      end
      hs_count++;
      pos = (pos + 1) % NP;
      if (pos == 0) last_hs_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      chk("busy_on_done", 24'(busy), 24'd1);
      if (done_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_frame_done: got pulse expected none at cycle %0d", cyc);
      end else begin
        mon_d = done_q.pop_front();
        chk("done_latency", 24'(cyc - last_hs_cyc), 24'(mon_d));
      end
      done_count++;
      after_done = 1'b1;
    end
    post = mon_hs ? 1 : ((post == 1) ? 2 : 0);
    if (RST) begin pos = 0; post = 0; end
    prev_valid = (pix_valid === 1'b1);
    prev_hs    = mon_hs;
    prev_data  = pix_data;
    prev_rst   = RST;
  end

  initial begin
    RST = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    chk("rst_busy", 24'(busy), 24'd0);
    chk("rst_frame_done", 24'(frame_done), 24'd0);
    chk("rst_pix_valid", 24'(pix_valid), 24'd0);
    chk("rst_pix_data", pix_data, 24'd0);
    tick();
    RST = 1'b0;

    // Frame A: bank 1 holds 1..8; bank 0 is filled while A streams.
    for (int i = 0; i < NP; i++) wr(AW'(i), 24'(i + 1));
    for (int i = 0; i < NP; i++) exp_q.push_back(24'(i + 1));
    done_q.push_back(GAP + LC + 1);
    start();
    for (int i = 0; i < NP; i++) wr(AW'(i), (i == 3) ? 24'hFF0000 : 24'h000101 + 24'(i));
    wr(AW'(9), 24'hBADBAD);
    wait_hs(2);
    start();
    wait_done(1);

    // Frame B: bank 0, long ready hold mid-frame, latch gap interrupted at count 400.
    for (int i = 0; i < NP; i++) exp_q.push_back((i == 3) ? 24'hFF0000 : 24'h000101 + 24'(i));
    done_q.push_back(GAP + LC + 411);
    start();
    wr(AW'(9), 24'hBADBAD);
    wait_hs(NP + 2);
    repeat (GAP - 10) @(negedge CLK);
    force_low = 1'b1;
    repeat (100) @(negedge CLK);
    force_low = 1'b0;
    wait_hs(NP + 3);
    start();
    wait_hs(2 * NP);
    repeat (GAP + 400) @(negedge CLK);
    force_low = 1'b1;
    repeat (10) @(negedge CLK);
    force_low = 1'b0;
    wait_done(2);

    // Frame C: bank 1, aborted by reset while pixel 4 is presented.
    for (int i = 0; i < 4; i++) exp_q.push_back(24'(i + 1));
    start();
    wait_hs(2 * NP + 4);
    repeat (5) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_pix_valid", 24'(pix_valid), 24'd0);
    chk("abort_busy", 24'(busy), 24'd0);
    chk("abort_frame_done", 24'(frame_done), 24'd0);
    repeat (LC + GAP + 50) tick();

    // Frame D: bank 1 again; the write beside frame_start hits the displayed bank.
    for (int i = 0; i < NP; i++) exp_q.push_back((i == 7) ? 24'h000077 : 24'(i + 1));
    done_q.push_back(GAP + LC + 1);
    frame_start = 1'b1; wr_en = 1'b1; wr_addr = AW'(7); wr_data = 24'h000077;
    tick();
    frame_start = 1'b0; wr_en = 1'b0;
    wait_done(3);
    repeat (3) tick();
    chk("pixels_outstanding", 24'(exp_q.size()), 24'd0);
    chk("dones_outstanding", 24'(done_q.size()), 24'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
